two_phase_channel_arbiter: RTL and testbench
============================================

Name: two_phase_channel_arbiter

Overview:
- Clocked controller that shares one two-phase (transition-signalling) req/ack channel among NUM_CLIENTS synchronous requesters.
- Arbitrates round-robin, issues one req transition per granted transaction and waits for the matching ack transition.
- Returns a one-cycle done pulse to the granted client.
- Detects ack timeouts and spurious ack transitions; sits between clocked client logic and an asynchronous two-phase slave.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..16).
- SYNC_STAGES, 2, flops in the out_ack synchronizer (>=2).
- TIMEOUT_CYCLES, 1024, max cycles from req transition to synchronized ack match; 0 disables timeout.
- CNT_W, 11, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- cli_req  input  NUM_CLIENTS  level request per client; held high until that client's cli_done.
- cli_done  output  NUM_CLIENTS  one-cycle pulse to the client whose transaction completed.
- grant_idx  output  $clog2(NUM_CLIENTS)  index of the current or last granted client.
- busy  output  1  high from grant until the done cycle.
- out_req  output  1  two-phase request to slave; toggles once per transaction.
- out_ack  input  1  two-phase ack from slave; asynchronous to clk.
- err_timeout  output  1  sticky; set on timeout.
- err_protocol  output  1  sticky; set on an unexpected ack transition.

Behaviour:
- Reset (sampled on clk rising edge while rst=1):
  - out_req=0, cli_done=0, busy=0, grant_idx=0, err_*=0.
  - Synchronizer flops cleared; round-robin pointer set so client 0 has highest priority; state IDLE.
  - Reset mid-transaction aborts it with no done pulse. The slave's ack must also return to 0 (system-level requirement).
- Synchronizer: ack_s = out_ack delayed through SYNC_STAGES flops. Only ack_s is used internally.
- States: IDLE, WAIT, DONE, ERR.
- IDLE:
  - If any cli_req is high, pick the first set bit searching upward (with wrap) from last_grant+1.
  - Register grant_idx, toggle out_req, set busy, clear the timeout counter, go to WAIT. out_req changes at the same edge, i.e. 1 cycle after cli_req is sampled.
  - If ack_s != out_req in IDLE: set err_protocol, go to ERR.
- WAIT:
  - Counter increments each cycle.
  - When ack_s == out_req, go to DONE.
  - Else if TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES-1: set err_timeout, go to ERR.
  - If an ack match and timeout land in the same cycle, the ack match wins.
- DONE (exactly one cycle):
  - cli_done[grant_idx]=1, busy=0, last_grant=grant_idx, then IDLE.
  - cli_req is not sampled for arbitration in DONE. The granted client must drop cli_req by the cycle after done; otherwise it is treated as a new request, after all other pending clients.
- ERR:
  - Terminal. out_req frozen, busy stays 1, no done, no further grants; exit only via rst.
- Minimum transaction latency is SYNC_STAGES+2 cycles from request sample to done, assuming the slave acks immediately.
- out_req is driven directly from a flop; no combinational path from any input.
- cli_req bits for non-granted clients may change at any time without effect on the current transaction.

Decomposition:
- Shared package: state enum (IDLE, WAIT, DONE, ERR) and a round-robin next-index function usable by other arbiters in the library.
- One sub-module: sync_ff (parameterised SYNC_STAGES bit synchronizer, synchronous active-high reset to 0), reused for any async input in the library.

Test Plan:
- Single client: cli_req[0]=1; the two_phase_slave-style model acks after 0..200 ns. Required: out_req 0->1 and cli_done[0] exactly one pulse. A second request toggles out_req 1->0; two done pulses total.
- Fairness: NUM_CLIENTS=4, all cli_req held high, each dropped one cycle after its done. Required: grant_idx sequence 0,1,2,3; with 0 and 2 re-asserted, order continues 0,2.
- Timeout: TIMEOUT_CYCLES=16, slave never acks. Required: err_timeout=1 exactly 16 cycles after out_req toggles; busy stays 1; no cli_done; a later ack has no effect.
- Protocol error: in IDLE, out_ack toggles 0->1. Required: err_protocol=1 within SYNC_STAGES+1 cycles; no grant issued even with cli_req=4'b0001.
- Reset mid-transaction: rst in WAIT with out_req=1, slave ack also reset. Required: next edge out_req=0, busy=0, no done; a fresh request then completes normally.
- Ack/timeout collision: TIMEOUT_CYCLES=8, ack timed so ack_s matches on counter=7. Required: DONE taken, err_timeout stays 0.

Source files
------------

// File: rtl/two_phase_channel_arbiter_pkg.sv
// Shared types and helpers for the channel arbiters: controller state encoding
// and a round-robin picker that any arbiter with up to 16 requesters can reuse.
package two_phase_channel_arbiter_pkg;

   localparam int unsigned RR_MAX_CLIENTS = 16;
   localparam int unsigned RR_IDX_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set request searching upward from last+1, wrapping at n.
   // Requires last < n and n <= RR_MAX_CLIENTS.
   function automatic rr_pick_t rr_next(
      input logic [RR_MAX_CLIENTS-1:0] req,
      input logic [RR_IDX_W-1:0]       last,
      input int                        n
   );
      rr_pick_t   pick;
      logic [4:0] cand;
      logic [4:0] span;
      pick = '0;
      span = 5'(n);
      cand = {1'b0, last};
      for (int k = 0; k < int'(RR_MAX_CLIENTS); k++) begin
         cand = cand + 5'd1;
         if (cand >= span) begin
            cand = cand - span;
         end
         if (!pick.found && (k < n) && req[cand[3:0]]) begin
            pick.found = 1'b1;
            pick.idx   = cand[3:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/two_phase_channel_arbiter_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module two_phase_channel_arbiter_sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/two_phase_channel_arbiter.sv
// Round-robin arbiter sharing one two-phase req/ack channel among synchronous
// clients, with ack timeout and spurious-ack detection.
//
// state | meaning
// IDLE  | channel quiet (ack_s == out_req); grant the next pending client
// WAIT  | req transition issued; waiting for ack_s to match, timeout counting
// DONE  | one cycle: done pulse to granted client, advance round-robin pointer
// ERR   | timeout or spurious ack seen; frozen until reset
module two_phase_channel_arbiter
   import two_phase_channel_arbiter_pkg::*;
#(
   parameter int NUM_CLIENTS    = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CLIENTS-1:0]         cli_req,
   output logic [NUM_CLIENTS-1:0]         cli_done,
   output logic [$clog2(NUM_CLIENTS)-1:0] grant_idx,
   output logic                           busy,
   output logic                           out_req,
   input  logic                           out_ack,
   output logic                           err_timeout,
   output logic                           err_protocol
);

   localparam int               IDX_W     = $clog2(NUM_CLIENTS);
   localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_CLIENTS - 1);

   arb_state_e             state_q, state_d;
   logic                   out_req_q, out_req_d;
   logic                   busy_q, busy_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_CLIENTS-1:0] done_q, done_d;
   logic                   err_to_q, err_to_d;
   logic                   err_pr_q, err_pr_d;
   logic                   ack_s;
   rr_pick_t               pick;

   two_phase_channel_arbiter_sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (out_ack),
      .q   (ack_s)
   );

   always_comb begin
      pick = rr_next(RR_MAX_CLIENTS'(cli_req), RR_IDX_W'(last_q), NUM_CLIENTS);
   end

   always_comb begin
      state_d   = state_q;
      out_req_d = out_req_q;
      busy_d    = busy_q;
      grant_d   = grant_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      done_d    = '0;
      err_to_d  = err_to_q;
      err_pr_d  = err_pr_q;

      case (state_q)
         ST_IDLE: begin
            // A quiet channel must have ack equal to req; anything else is a stray ack.
            if (ack_s != out_req_q) begin
               err_pr_d = 1'b1;
               state_d  = ST_ERR;
            end else if (pick.found) begin
               grant_d   = IDX_W'(pick.idx);
               out_req_d = ~out_req_q;
               busy_d    = 1'b1;
               cnt_d     = '0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // Ack match is checked first so it wins a tie with the timeout.
            if (ack_s == out_req_q) begin
               busy_d  = 1'b0;
               done_d  = NUM_CLIENTS'(1) << grant_q;
               state_d = ST_DONE;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               err_to_d = 1'b1;
               state_d  = ST_ERR;
            end
         end
         ST_DONE: begin
            last_d  = grant_q;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         out_req_q <= 1'b0;
         busy_q    <= 1'b0;
         grant_q   <= '0;
         last_q    <= LAST_INIT;
         cnt_q     <= '0;
         done_q    <= '0;
         err_to_q  <= 1'b0;
         err_pr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_req_q <= out_req_d;
         busy_q    <= busy_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         err_to_q  <= err_to_d;
         err_pr_q  <= err_pr_d;
      end
   end

   assign cli_done     = done_q;
   assign grant_idx    = grant_q;
   assign busy         = busy_q;
   assign out_req      = out_req_q;
   assign err_timeout  = err_to_q;
   assign err_protocol = err_pr_q;

endmodule

// File: tb/tb_two_phase_channel_arbiter.sv
// Bench for two_phase_channel_arbiter: directed scenarios plus randomized
// request/ack-delay traffic checked against a round-robin queue model.
module tb_two_phase_channel_arbiter;

   localparam int N  = 4;
   localparam int S  = 2;
   localparam int TO = 16;
   localparam int CW = 11;
   localparam int IW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  cli_req = '0;
   logic [N-1:0]  cli_done;
   logic [IW-1:0] grant_idx;
   logic          busy;
   logic          out_req;
   logic          out_ack = 1'b0;
   logic          err_timeout;
   logic          err_protocol;

   int n_cmp = 0;
   int n_bad = 0;
   int model_last = N - 1;

   always #5 clk = ~clk;

   two_phase_channel_arbiter #(
      .NUM_CLIENTS    (N),
      .SYNC_STAGES    (S),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cli_req      (cli_req),
      .cli_done     (cli_done),
      .grant_idx    (grant_idx),
      .busy         (busy),
      .out_req      (out_req),
      .out_ack      (out_ack),
      .err_timeout  (err_timeout),
      .err_protocol (err_protocol)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

   // Round-robin reference: first pending client after the last one served.
   function automatic int model_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         if (req[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      cli_req = '0;
      out_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst        = 1'b0;
      model_last = N - 1;
   endtask

   // Acting slave: wait for the req transition, ack after d cycles, then wait
   // for a done pulse. lat counts negedges from the one showing the req toggle.
   task automatic run_txn(input int d, output int g, output int lat,
                          output logic [N-1:0] dseen, output logic ok);
      logic prev;
      logic seen;
      prev  = out_req;
      ok    = 1'b0;
      g     = -1;
      lat   = -1;
      dseen = '0;
      seen  = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = (out_req != prev);
      end
      if (!seen) return;
      g = int'(grant_idx);
      for (int i = 0; i < d; i++) @(negedge clk);
      out_ack = out_req;
      for (int t = d + 1; t <= d + 60; t++) begin
         @(negedge clk);
         if (cli_done != '0) begin
            lat   = t;
            dseen = cli_done;
            ok    = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (out_req !== 1'b0) begin n_bad++; $display("FAIL reset_out_req: got %b want 0", out_req); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (cli_done !== '0) begin n_bad++; $display("FAIL reset_done: got %b want 0", cli_done); end
      n_cmp++; if (grant_idx !== '0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", grant_idx); end
      n_cmp++; if ({err_timeout, err_protocol} !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b%b want 00", err_timeout, err_protocol); end
   endtask

   task automatic test_single_client();
      int   pulses;
      logic prev;
      logic seen;
      do_reset();
      pulses = 0;
      for (int r = 0; r < 2; r++) begin
         prev    = out_req;
         cli_req = N'(1);
         seen    = 1'b0;
         for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = busy;
         end
         n_cmp++; if (out_req !== ~prev) begin n_bad++; $display("FAIL single_toggle[%0d]: got %b want %b", r, out_req, ~prev); end
         #($urandom_range(0, 100));
         out_ack = out_req;
         for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (cli_done != '0) begin
               pulses++;
               n_cmp++; if (cli_done !== N'(1)) begin n_bad++; $display("FAIL single_done_vec[%0d]: got %b want 0001", r, cli_done); end
               cli_req[0] = 1'b0;
            end
         end
      end
      n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL single_pulses: got %0d want 2", pulses); end
   endtask

   task automatic test_fairness();
      int           seq [6];
      int           exp_seq [6];
      int           g, lat, exp_g;
      logic [N-1:0] dseen;
      logic         ok;
      exp_seq = '{0, 1, 2, 3, 0, 2};
      do_reset();
      cli_req = '1;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) cli_req = N'(4'b0101);
         exp_g = model_pick(cli_req, model_last);
         run_txn(0, g, lat, dseen, ok);
         seq[i] = g;
         n_cmp++; if (ok !== 1'b1 || g !== exp_g) begin n_bad++; $display("FAIL fair_grant[%0d]: got %0d (ok=%b) want %0d", i, g, ok, exp_g); end
         n_cmp++; if (lat !== S + 1) begin n_bad++; $display("FAIL fair_latency[%0d]: got %0d want %0d", i, lat, S + 1); end
         n_cmp++; if (exp_g >= 0 && dseen !== (N'(1) << exp_g)) begin n_bad++; $display("FAIL fair_done[%0d]: got %b want client %0d", i, dseen, exp_g); end
         model_last = exp_g;
         if (g >= 0 && g < N) cli_req[g] = 1'b0;
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++; if (seq[i] !== exp_seq[i]) begin n_bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, seq[i], exp_seq[i]); end
      end
   endtask

   task automatic test_random();
      int           g, lat, d, exp_g;
      logic [N-1:0] dseen;
      logic         ok;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         cli_req = cli_req | N'($urandom_range(0, (1 << N) - 1));
         if (cli_req == '0) cli_req[$urandom_range(0, N - 1)] = 1'b1;
         exp_g = model_pick(cli_req, model_last);
         d = $urandom_range(0, 8);
         run_txn(d, g, lat, dseen, ok);
         n_cmp++; if (ok !== 1'b1 || g !== exp_g) begin n_bad++; $display("FAIL rand_grant[%0d]: got %0d (ok=%b) want %0d req=%b", i, g, ok, exp_g, cli_req); end
         n_cmp++; if (lat !== S + 1 + d) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, S + 1 + d); end
         n_cmp++; if (dseen !== (N'(1) << exp_g)) begin n_bad++; $display("FAIL rand_done[%0d]: got %b want client %0d", i, dseen, exp_g); end
         model_last = exp_g;
         // Sometimes the granted client keeps requesting: it must queue behind the others.
         if ($urandom_range(0, 3) != 0 && g >= 0 && g < N) cli_req[g] = 1'b0;
      end
      n_cmp++; if ({err_timeout, err_protocol} !== 2'b00) begin n_bad++; $display("FAIL rand_err: got %b%b want 00", err_timeout, err_protocol); end
   endtask

   task automatic test_timeout();
      logic prev, seen, req_now, any_done;
      do_reset();
      prev     = out_req;
      cli_req  = N'(1);
      seen     = 1'b0;
      any_done = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = (out_req != prev);
      end
      req_now = out_req;
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL to_grant: got no req toggle want toggle"); end
      for (int t = 1; t <= TO + 4; t++) begin
         @(negedge clk);
         if (cli_done != '0) any_done = 1'b1;
         if (t == TO - 1) begin
            n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0 at cycle %0d", err_timeout, t); end
         end
         if (t == TO) begin
            n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_set: got %b want 1 at cycle %0d", err_timeout, t); end
         end
      end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL to_busy: got %b want 1", busy); end
      out_ack = out_req;
      repeat (10) begin
         @(negedge clk);
         if (cli_done != '0) any_done = 1'b1;
      end
      n_cmp++; if (any_done !== 1'b0) begin n_bad++; $display("FAIL to_no_done: got done pulse want none"); end
      n_cmp++; if (out_req !== req_now) begin n_bad++; $display("FAIL to_req_frozen: got %b want %b", out_req, req_now); end
      n_cmp++; if ({err_timeout, err_protocol, busy} !== 3'b101) begin n_bad++; $display("FAIL to_late_ack: got to=%b pr=%b busy=%b want 1 0 1", err_timeout, err_protocol, busy); end
   endtask

   task automatic test_collision();
      int           g, lat;
      logic [N-1:0] dseen;
      logic         ok;
      do_reset();
      cli_req = N'(1);
      run_txn(TO - 1 - S, g, lat, dseen, ok);
      cli_req = '0;
      n_cmp++; if (ok !== 1'b1 || lat !== TO) begin n_bad++; $display("FAIL coll_done: got ok=%b lat=%0d want ok=1 lat=%0d", ok, lat, TO); end
      n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL coll_err: got %b want 0", err_timeout); end
      // One cycle later the timeout must win.
      cli_req = N'(2);
      run_txn(TO - S, g, lat, dseen, ok);
      n_cmp++; if (ok !== 1'b0 || err_timeout !== 1'b1) begin n_bad++; $display("FAIL coll_late: got ok=%b to=%b want ok=0 to=1", ok, err_timeout); end
   endtask

   task automatic test_protocol();
      logic any_done;
      do_reset();
      @(negedge clk);
      out_ack  = 1'b1;
      any_done = 1'b0;
      for (int t = 1; t <= S + 1; t++) begin
         @(negedge clk);
         if (t == S) begin
            n_cmp++; if (err_protocol !== 1'b0) begin n_bad++; $display("FAIL prot_early: got %b want 0", err_protocol); end
         end
      end
      n_cmp++; if (err_protocol !== 1'b1) begin n_bad++; $display("FAIL prot_set: got %b want 1", err_protocol); end
      cli_req = N'(1);
      repeat (10) begin
         @(negedge clk);
         if (cli_done != '0) any_done = 1'b1;
      end
      n_cmp++; if (out_req !== 1'b0 || any_done !== 1'b0) begin n_bad++; $display("FAIL prot_no_grant: got out_req=%b done=%b want 0 0", out_req, any_done); end
      n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL prot_to: got %b want 0", err_timeout); end
   endtask

   task automatic test_reset_mid();
      int           g, lat;
      logic [N-1:0] dseen;
      logic         ok, prev, seen;
      do_reset();
      prev    = out_req;
      cli_req = N'(1);
      seen    = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = (out_req != prev);
      end
      repeat (3) @(negedge clk);
      rst     = 1'b1;
      out_ack = 1'b0;
      @(negedge clk);
      n_cmp++; if ({out_req, busy} !== 2'b00 || cli_done !== '0) begin n_bad++; $display("FAIL mid_reset: got req=%b busy=%b done=%b want 0 0 0", out_req, busy, cli_done); end
      rst        = 1'b0;
      model_last = N - 1;
      run_txn(1, g, lat, dseen, ok);
      n_cmp++; if (ok !== 1'b1 || g !== 0 || lat !== S + 2 || dseen !== N'(1)) begin n_bad++; $display("FAIL mid_fresh: got ok=%b g=%0d lat=%0d done=%b want 1 0 %0d 0001", ok, g, lat, dseen, S + 2); end
      n_cmp++; if (out_req !== 1'b1) begin n_bad++; $display("FAIL mid_req: got %b want 1", out_req); end
      cli_req = '0;
   endtask

   initial begin
      test_reset();
      test_single_client();
      test_fairness();
      test_random();
      test_timeout();
      test_collision();
      test_protocol();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
